// File: rtl/watbulb_sync_fifo_param.sv
// Parametrised single-clock FIFO with thresholds, occupancy count, flush and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; the default is a registered read.
module watbulb_sync_fifo_param #(
    parameter int DATA_W        = 6,
    parameter int DEPTH         = 8,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       clr_err,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AFULL_C  = (ADDR_W+1)'(AFULL_THRESH);
    localparam logic [ADDR_W:0]   AEMPTY_C = (ADDR_W+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic              overflow_reg, overflow_next;
    logic              underflow_reg, underflow_next;
    logic              wr_acc, rd_acc;

    assign full         = (count_reg == DEPTH_C);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= AFULL_C);
    assign almost_empty = (count_reg <= AEMPTY_C);
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // A flush swallows both requests, so nothing is accepted or flagged in that cycle.
    always_comb begin
        rd_acc = rd_en & ~empty & ~flush;
        wr_acc = wr_en & ~flush & (~full | rd_acc);
    end

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg & ~clr_err;
        underflow_next = underflow_reg & ~clr_err;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (wr_acc) wr_ptr_next = wr_ptr_reg + PTR_ONE;
            if (rd_acc) rd_ptr_next = rd_ptr_reg + PTR_ONE;
            case ({wr_acc, rd_acc})
                2'b10:   count_next = count_reg + CNT_ONE;
                2'b01:   count_next = count_reg - CNT_ONE;
                default: count_next = count_reg;
            endcase
            // A new error beats a simultaneous clear.
            if (wr_en & ~wr_acc) overflow_next  = 1'b1;
            if (rd_en & ~rd_acc) underflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Storage is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr_reg] <= wr_data;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data = mem[rd_ptr_reg];
`else
    logic [DATA_W-1:0] rd_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rd_data_reg <= '0;
        else if (rd_acc) rd_data_reg <= mem[rd_ptr_reg];
    end

    assign rd_data = rd_data_reg;
`endif

endmodule

// File: tb/tb_watbulb_sync_fifo_param.sv
// Directed self-checking bench for watbulb_sync_fifo_param (DATA_W=6, DEPTH=8, thresholds 6/1).
// Read-data expectations follow SYNC_FIFO_FWFT_EN when it is defined.
module tb_watbulb_sync_fifo_param;
    logic       clk = 1'b0;
    logic       rst_n, flush, clr_err, wr_en, rd_en;
    logic [5:0] wr_data, rd_data;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    int tests_run = 0;
    int tests_failed = 0;

    watbulb_sync_fifo_param #(
        .DATA_W(6), .DEPTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
        .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [5:0] d);
        wr_en = 1'b1; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [5:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
        check_eq(tag, {26'd0, rd_data}, {26'd0, exp});
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
`else
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_eq(tag, {26'd0, rd_data}, {26'd0, exp});
`endif
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; clr_err = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_count", {28'd0, count}, 32'd0);
        check_eq("rst_empty", {31'd0, empty}, 32'd1);
        check_eq("rst_full", {31'd0, full}, 32'd0);
        check_eq("rst_aempty", {31'd0, almost_empty}, 32'd1);
        check_eq("rst_afull", {31'd0, almost_full}, 32'd0);

        // 1: reset mid-stream after 3 writes (one read first so rd_data is non-zero)
        do_write(6'h11); do_write(6'h12); do_write(6'h13);
        check_eq("t1_count3", {28'd0, count}, 32'd3);
        do_read("t1_rd0", 6'h11);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t1_count", {28'd0, count}, 32'd0);
        check_eq("t1_empty", {31'd0, empty}, 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
        check_eq("t1_rd_data", {26'd0, rd_data}, 32'd0);
`endif
        check_eq("t1_ovf", {31'd0, overflow}, 32'd0);
        check_eq("t1_unf", {31'd0, underflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // 2: fill with 1..8 then drain in order
        for (int i = 1; i <= 8; i++) begin
            do_write(6'(i));
            check_eq($sformatf("t2_count_w%0d", i), {28'd0, count}, 32'(i));
            check_eq($sformatf("t2_afull_w%0d", i), {31'd0, almost_full}, 32'(i >= 6));
            check_eq($sformatf("t2_full_w%0d", i), {31'd0, full}, 32'(i == 8));
        end
        for (int i = 1; i <= 8; i++) begin
            do_read($sformatf("t2_rd%0d", i), 6'(i));
            check_eq($sformatf("t2_count_r%0d", i), {28'd0, count}, 32'(8 - i));
            check_eq($sformatf("t2_aempty_r%0d", i), {31'd0, almost_empty}, 32'(8 - i <= 1));
        end
        check_eq("t2_empty", {31'd0, empty}, 32'd1);
        check_eq("t2_unf", {31'd0, underflow}, 32'd0);

        // 3: overflow on full, then clear
        for (int i = 0; i < 8; i++) do_write(6'h20 + 6'(i));
        do_write(6'h2A);
        check_eq("t3_count", {28'd0, count}, 32'd8);
        check_eq("t3_ovf", {31'd0, overflow}, 32'd1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check_eq("t3_ovf_clr", {31'd0, overflow}, 32'd0);
        check_eq("t3_count_hold", {28'd0, count}, 32'd8);

        // 4: simultaneous read+write when full
`ifdef SYNC_FIFO_FWFT_EN
        check_eq("t4_head", {26'd0, rd_data}, 32'h20);
`endif
        rd_en = 1'b1; wr_en = 1'b1; wr_data = 6'h15;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
`ifndef SYNC_FIFO_FWFT_EN
        check_eq("t4_head", {26'd0, rd_data}, 32'h20);
`endif
        check_eq("t4_count", {28'd0, count}, 32'd8);
        check_eq("t4_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 1; i < 8; i++) do_read($sformatf("t4_rd%0d", i), 6'h20 + 6'(i));
        do_read("t4_rd_last", 6'h15);
        check_eq("t4_empty", {31'd0, empty}, 32'd1);

        // 5: simultaneous read+write when empty
        rd_en = 1'b1; wr_en = 1'b1; wr_data = 6'h33;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        check_eq("t5_count", {28'd0, count}, 32'd1);
        check_eq("t5_unf", {31'd0, underflow}, 32'd1);
        do_read("t5_rd", 6'h33);
        rd_en = 1'b1; clr_err = 1'b1;
        tick();
        rd_en = 1'b0; clr_err = 1'b0;
        check_eq("t5_set_wins", {31'd0, underflow}, 32'd1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check_eq("t5_unf_clr", {31'd0, underflow}, 32'd0);

        // 6: pointer wrap, then flush mid-fill
        for (int i = 1; i <= 5; i++) do_write(6'h30 + 6'(i));
        for (int i = 1; i <= 5; i++) do_read($sformatf("t6a_rd%0d", i), 6'h30 + 6'(i));
        for (int i = 1; i <= 6; i++) do_write(6'h10 + 6'(i));
        for (int i = 1; i <= 6; i++) do_read($sformatf("t6b_rd%0d", i), 6'h10 + 6'(i));
        do_write(6'h0A); do_write(6'h0B); do_write(6'h0C);
        check_eq("t6_count3", {28'd0, count}, 32'd3);
        flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 6'h3F;
        tick();
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        check_eq("t6_flush_count", {28'd0, count}, 32'd0);
        check_eq("t6_flush_empty", {31'd0, empty}, 32'd1);
        check_eq("t6_flush_ovf", {31'd0, overflow}, 32'd0);
        check_eq("t6_flush_unf", {31'd0, underflow}, 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
        check_eq("t6_flush_hold", {26'd0, rd_data}, 32'h16);
`endif
        do_write(6'h3C);
        check_eq("t6_post_count", {28'd0, count}, 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
        check_eq("t6_fwft_head", {26'd0, rd_data}, 32'h3C);
`endif
        do_read("t6_post_rd", 6'h3C);
        check_eq("t6_final_empty", {31'd0, empty}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
